cc_dff_pipe_bank: RTL

//  Parametrised bank of WIDTH independent flip-flop channels. Each channel is DEPTH stages deep and has per-channel

---
 rtl/cc_dff_bank_pkg.sv | 21 ++
 rtl/cc_dff_pipe_bank_if.sv | 36 +++
 rtl/cc_dff_bank_readback.sv | 79 +++++++
 rtl/cc_dff_pipe_bank.sv | 79 +++++++
 4 files changed

// File: rtl/cc_dff_bank_pkg.sv
// +-----------------------------------------------------------------------------+
// | cc_dff_bank_pkg : shared types and helpers for the cc_dff_pipe_bank slice   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package cc_dff_bank_pkg;

  typedef enum logic [0:0] {
    RB_IDLE  = 1'b0,
    RB_SHIFT = 1'b1
  } rb_state_t;

  // Index width for the readback counter; a single channel still needs one bit.
  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cc_dff_pipe_bank_if.sv
// +-----------------------------------------------------------------------------+
// | cc_dff_pipe_bank_if : serial readback handshake between bank and its sink   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface cc_dff_pipe_bank_if;

  logic rb_start;
  logic rb_ready;
  logic rb_valid;
  logic rb_data;
  logic rb_last;
  logic rb_busy;

  modport master (
    output rb_start,
    output rb_ready,
    input  rb_valid,
    input  rb_data,
    input  rb_last,
    input  rb_busy
  );

  modport slave (
    input  rb_start,
    input  rb_ready,
    output rb_valid,
    output rb_data,
    output rb_last,
    output rb_busy
  );

endinterface

`default_nettype wire

// File: rtl/cc_dff_bank_readback.sv
// +-----------------------------------------------------------------------------+
// | cc_dff_bank_readback : snapshots q and streams it out LSB first            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module cc_dff_bank_readback
  import cc_dff_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] q,
  cc_dff_pipe_bank_if.slave rb
);

  localparam int               IDX_W    = idx_w(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  rb_state_t        r_state;
  rb_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_snap;
  logic [WIDTH-1:0] w_snap_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RB_IDLE;
      r_snap  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_snap  <= w_snap_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // rb_start is only looked at in IDLE, so a request during SHIFT (including
  // the final-transfer cycle) is dropped rather than queued.
  always_comb begin
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    w_idx_nxt   = r_idx;
    w_last      = (r_idx == LAST_IDX);
    rb.rb_valid = 1'b0;
    rb.rb_busy  = 1'b0;
    rb.rb_data  = 1'b0;
    rb.rb_last  = 1'b0;
    case (r_state)
      RB_IDLE: begin
        if (rb.rb_start) begin
          w_snap_nxt  = q;
          w_idx_nxt   = '0;
          w_state_nxt = RB_SHIFT;
        end
      end
      RB_SHIFT: begin
        rb.rb_valid = 1'b1;
        rb.rb_busy  = 1'b1;
        rb.rb_data  = r_snap[r_idx];
        rb.rb_last  = w_last;
        if (rb.rb_ready) begin
          if (w_last) begin
            w_state_nxt = RB_IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = RB_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cc_dff_pipe_bank.sv
// +-----------------------------------------------------------------------------+
// | cc_dff_pipe_bank : WIDTH x DEPTH CC_DFF pipe bank, optional serial readback |
// | Readback built when CC_DFF_BANK_READBACK_EN is defined.       Rev 1.0       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module cc_dff_pipe_bank
  import cc_dff_bank_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter int               DEPTH  = 3,
  parameter logic [WIDTH-1:0] EN_INV = '0,
  parameter logic [WIDTH-1:0] SR_INV = '0,
  parameter logic [WIDTH-1:0] SR_VAL = '0,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] sr,
  output logic [WIDTH-1:0] q,
  cc_dff_pipe_bank_if.slave rb
);

  logic [WIDTH-1:0] w_en_e;
  logic [WIDTH-1:0] w_sr_e;

  assign w_en_e = en ^ EN_INV;
  assign w_sr_e = sr ^ SR_INV;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
      logic w_src;
      logic r_bit;

      if (k == 0) begin : g_head
        assign w_src = d[i];
      end else begin : g_tail
        assign w_src = g_stg[k-1].r_bit;
      end

      // A disabled channel freezes every stage, so no bubble enters the pipe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_bit <= INIT[i];
        end else if (w_sr_e[i]) begin
          r_bit <= SR_VAL[i];
        end else if (w_en_e[i]) begin
          r_bit <= w_src;
        end
      end
    end

    assign q[i] = g_stg[DEPTH-1].r_bit;
  end

`ifdef CC_DFF_BANK_READBACK_EN
  cc_dff_bank_readback #(
    .WIDTH (WIDTH)
  ) u_readback (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q),
    .rb    (rb)
  );
`else
  logic w_unused_rb;

  assign rb.rb_valid  = 1'b0;
  assign rb.rb_data   = 1'b0;
  assign rb.rb_last   = 1'b0;
  assign rb.rb_busy   = 1'b0;
  assign w_unused_rb  = rb.rb_start ^ rb.rb_ready;
`endif

endmodule

`default_nettype wire
